// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory stream reader.
//   clog2()  - address-width helper, never returns less than 1
//   state_t  - burst controller state encoding
package mem_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_rd_fifo.sv
// mem_rd_fifo: 3-entry synchronous FIFO that buffers memory read data.
// Ports:
//   clock, reset_n  - clock and asynchronous active-low reset (pointers/count only)
//   push, wr_data   - write one entry on the rising edge
//   pop             - drop the head entry on the rising edge (only when non-empty)
//   rd_data         - head entry, driven straight from storage (no output register)
//   count           - current occupancy, 0..3
module mem_rd_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] storage [3];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;

  function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
    return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Data storage carries no reset; the consumer qualifies it with count.
  always_ff @(posedge clock) begin
    if (push) storage[wr_ptr] <= wr_data;
  end

  assign rd_data = storage[rd_ptr];

endmodule

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: reads a burst of 'length' words from a synchronous-read
// memory starting at 'base_addr' (wrapping at DEPTH-1) and presents them as a
// valid/ready stream in address order.
// Ports:
//   clock, reset_n          - clock, asynchronous active-low reset
//   start, base_addr, length- burst request, sampled only in IDLE
//   busy, done              - burst in progress / one-cycle completion pulse
//   mem_rdaddress, mem_rden - memory read port (address valid when mem_rden)
//   mem_q                   - memory read data, valid the cycle after mem_rden
//   out_data, out_valid     - stream output
//   out_ready               - stream sink ready
module mem_stream_reader
  import mem_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 64,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      length,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    mem_rdaddress,
  output logic             mem_rden,
  input  logic [WIDTH-1:0] mem_q,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t           state;
  logic [AW-1:0]    addr_q;
  logic [AW:0]      issued_q;
  logic [AW:0]      len_q;
  logic             inflight_q;

  logic [1:0]       fifo_count;
  logic [WIDTH-1:0] fifo_head;
  logic [2:0]       occupancy;
  logic             pop;
  logic             last_word;
  logic [AW-1:0]    addr_next;

  // Reads are throttled on registered occupancy only, so out_ready never
  // reaches the memory port combinationally. Buffered + in-flight is capped
  // at 3, which is exactly the FIFO depth, so the FIFO can never overflow.
  always_comb begin
    occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
    mem_rden  = (state == ST_READ) && (occupancy < 3'd3);
    pop       = out_valid && out_ready;
    last_word = (state == ST_DRAIN) && !inflight_q && (fifo_count == 2'd1) && pop;
    addr_next = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      issued_q   <= '0;
      len_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      // The in-flight flag marks the cycle in which mem_q carries read data.
      inflight_q <= mem_rden;
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q   <= base_addr;
            len_q    <= length;
            issued_q <= '0;
            state    <= (length == '0) ? ST_DONE : ST_READ;
          end
        end
        ST_READ: begin
          if (mem_rden) begin
            addr_q   <= addr_next;
            issued_q <= issued_q + 1'b1;
            if ((issued_q + 1'b1) == len_q) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (last_word) state <= ST_DONE;
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  mem_rd_fifo #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (inflight_q),
    .wr_data (mem_q),
    .pop     (pop),
    .rd_data (fifo_head),
    .count   (fifo_count)
  );

  assign busy          = (state == ST_READ) || (state == ST_DRAIN);
  assign done          = (state == ST_DONE);
  assign mem_rdaddress = addr_q;
  assign out_valid     = (fifo_count != 2'd0);
  // Gate the unreset storage so out_data reads zero whenever nothing is valid.
  assign out_data      = out_valid ? fifo_head : '0;

endmodule

// File: tb/tb_mem_stream_reader.sv
// tb_mem_stream_reader: randomized scoreboard bench for mem_stream_reader
// (WIDTH=8, DEPTH=64) with a synchronous-read memory model holding mem[i]=i.
module tb_mem_stream_reader;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [5:0] base_addr;
  logic [6:0] length;
  logic       busy;
  logic       done;
  logic [5:0] mem_rdaddress;
  logic       mem_rden;
  logic [7:0] mem_q;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  mem_stream_reader #(
    .WIDTH (8),
    .DEPTH (64)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .base_addr     (base_addr),
    .length        (length),
    .busy          (busy),
    .done          (done),
    .mem_rdaddress (mem_rdaddress),
    .mem_rden      (mem_rden),
    .mem_q         (mem_q),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: registered read, contents equal to address.
  logic [7:0] tb_mem [64];
  initial begin
    for (int i = 0; i < 64; i++) tb_mem[i] = 8'(i);
    mem_q = 8'h00;
  end
  always @(posedge clock) if (mem_rden) mem_q <= tb_mem[mem_rdaddress];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // Scoreboard and per-burst statistics
  logic [7:0] exp_q [$];
  int rden_cnt, xfer_cnt, done_cnt, max_out;
  int first_rden_cyc, first_valid_cyc, last_xfer_cyc, done_cyc, start_cyc;
  bit prev_stall;
  logic [7:0] prev_data;

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    prev_stall = 0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_stall = 0;
      end else begin
        if (mem_rden) begin
          rden_cnt++;
          if (first_rden_cyc < 0) first_rden_cyc = cyc;
          chk(busy, "rden_only_when_busy", busy, 1);
        end
        if (rden_cnt - xfer_cnt > max_out) max_out = rden_cnt - xfer_cnt;
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (prev_stall)
          chk(out_valid && out_data == prev_data, "stall_stable", out_data, prev_data);
        if (out_valid && out_ready) begin
          xfer_cnt++;
          last_xfer_cyc = cyc;
          chk(exp_q.size() != 0, "unexpected_word", out_data, -1);
          if (exp_q.size() != 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk(out_data == e, "out_data", out_data, e);
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          chk(!busy, "busy_low_in_done", busy, 0);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  // Sink ready driver: mode 0 always ready, mode 1 random with a 5-cycle stall.
  int rdy_mode = 0;
  int rdy_cnt  = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #2;
      if (rdy_mode == 0) out_ready = 1'b1;
      else begin
        rdy_cnt++;
        if (rdy_cnt >= 6 && rdy_cnt <= 10) out_ready = 1'b0;
        else out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Call at a falling edge; returns at the falling edge of the cycle after start is sampled.
  task automatic start_burst(input int b, input int l);
    for (int k = 0; k < l; k++) exp_q.push_back(8'((b + k) % 64));
    rden_cnt = 0; xfer_cnt = 0; done_cnt = 0; max_out = 0;
    first_rden_cyc = -1; first_valid_cyc = -1; last_xfer_cyc = -1; done_cyc = -1;
    base_addr = 6'(b);
    length    = 7'(l);
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic run_burst(input int b, input int l, input int mode, input bit timing, input bit inject);
    bit seen;
    rdy_mode = mode;
    rdy_cnt  = 0;
    start_burst(b, l);
    seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      if (done) seen = 1;
      else begin
        if (inject && i == 2) begin start = 1'b1; base_addr = 6'd40; length = 7'd7; end
        if (inject && i == 3) start = 1'b0;
        @(negedge clock);
      end
    end
    start = 1'b0;
    chk(seen, "done_timeout", seen, 1);
    if (inject) begin start = 1'b1; base_addr = 6'd40; length = 7'd3; end
    @(negedge clock);
    start = 1'b0;
    chk(!busy && !done, "idle_after_done", {busy, done}, 0);
    repeat (3) @(negedge clock);
    chk(exp_q.size() == 0, "words_missing", exp_q.size(), 0);
    chk(done_cnt == 1, "done_pulses", done_cnt, 1);
    chk(rden_cnt == l, "read_count", rden_cnt, l);
    chk(max_out <= 3, "max_outstanding", max_out, 3);
    if (l == 0) begin
      chk(done_cyc - start_cyc == 1, "zero_len_done_lat", done_cyc - start_cyc, 1);
      chk(first_valid_cyc < 0, "zero_len_no_valid", first_valid_cyc, -1);
    end else begin
      chk(done_cyc == last_xfer_cyc + 1, "done_after_last", done_cyc, last_xfer_cyc + 1);
    end
    if (timing && l > 0) begin
      chk(first_rden_cyc - start_cyc == 1, "first_rden_lat", first_rden_cyc - start_cyc, 1);
      chk(first_valid_cyc - start_cyc == 3, "first_valid_lat", first_valid_cyc - start_cyc, 3);
      chk(last_xfer_cyc - first_valid_cyc == l - 1, "throughput", last_xfer_cyc - first_valid_cyc, l - 1);
    end
    rdy_mode = 0;
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    #23;
    chk(busy == 0, "reset_busy", busy, 0);
    chk(done == 0, "reset_done", done, 0);
    chk(mem_rden == 0, "reset_rden", mem_rden, 0);
    chk(out_valid == 0, "reset_valid", out_valid, 0);
    chk(mem_rdaddress == 0, "reset_addr", mem_rdaddress, 0);
    chk(out_data == 0, "reset_data", out_data, 0);

    // Start on the first edge after reset release.
    @(negedge clock);
    reset_n = 1'b1;
    run_burst(5, 4, 0, 1, 0);
    run_burst(62, 4, 0, 1, 0);
    run_burst(0, 0, 0, 0, 0);
    run_burst(0, 10, 1, 0, 0);
    run_burst(3, 10, 0, 1, 1);

    // Reset in the middle of a burst, then a fresh short burst.
    rdy_mode = 0;
    start_burst(0, 10);
    for (int i = 0; i < 100 && xfer_cnt < 3; i++) @(negedge clock);
    chk(xfer_cnt >= 3, "reach_word3", xfer_cnt, 3);
    #1 reset_n = 1'b0;
    #1;
    chk(busy == 0, "midreset_busy", busy, 0);
    chk(done == 0, "midreset_done", done, 0);
    chk(mem_rden == 0, "midreset_rden", mem_rden, 0);
    chk(out_valid == 0, "midreset_valid", out_valid, 0);
    chk(mem_rdaddress == 0, "midreset_addr", mem_rdaddress, 0);
    chk(out_data == 0, "midreset_data", out_data, 0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    run_burst(20, 2, 0, 1, 0);

    run_burst(10, 64, 1, 0, 0);
    for (int n = 0; n < 4; n++) begin
      int b, l, m;
      b = $urandom_range(0, 63);
      l = $urandom_range(1, 64);
      m = $urandom_range(0, 1);
      run_burst(b, l, m, 0, 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_stream_reader.md
MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 Parameter WIDTH, default 8, data word width; SHALL match the attached memory.
REQ-002 Parameter DEPTH, default 64, memory word count; AW = CLOG2(DEPTH) SHALL be the address width.
REQ-003 clock  in  1  single clock, all state on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request a burst; sampled only when idle.
REQ-006 base_addr  in  AW  first word address, latched on accepted start.
REQ-007 length  in  AW+1  word count 0..DEPTH, latched on accepted start.
REQ-008 busy  out  1  burst in progress.
REQ-009 done  out  1  one-cycle pulse at burst completion.
REQ-010 mem_rdaddress  out  AW  read address to memory.
REQ-011 mem_rden  out  1  read enable to memory.
REQ-012 mem_q  in  WIDTH  memory registered read data, valid the cycle after mem_rden.
REQ-013 out_data  out  WIDTH  stream data.
REQ-014 out_valid  out  1  stream data valid.
REQ-015 out_ready  in  1  stream sink ready; transfer when out_valid and out_ready are both high.

Function
REQ-016 FSM states: IDLE, READ (issuing reads), DRAIN (all reads issued, buffer/in-flight non-empty), DONE (one cycle).
REQ-017 IDLE -> READ on start with length != 0; IDLE -> DONE on start with length == 0 (no mem_rden ever asserted).
REQ-018 start while not IDLE SHALL be ignored with no side effect.
REQ-019 READ: issue one read per cycle when (buffer occupancy + in-flight reads) < 3; address k SHALL be (base_addr + k) mod DEPTH (wrap-around at DEPTH-1 -> 0).
REQ-020 First mem_rden SHALL be asserted the cycle after start is sampled.
REQ-021 mem_q SHALL be written to a 3-entry FIFO on the edge ending the cycle after mem_rden; first out_valid SHALL appear exactly 2 cycles after first mem_rden.
REQ-022 No combinational path from out_ready to mem_rden or mem_rdaddress.
REQ-023 With out_ready held high, sustained throughput SHALL be one word per cycle.
REQ-024 While out_valid high and out_ready low, out_data SHALL stay stable; no word dropped or duplicated.
REQ-025 Words SHALL be delivered in address order, exactly length words.
REQ-026 READ -> DRAIN after the length-th read is issued; DRAIN -> DONE on the handshake of the last word.
REQ-027 DONE: done=1 for one cycle, busy=0, then IDLE; a start in the DONE cycle SHALL be ignored.
REQ-028 busy SHALL be high in READ and DRAIN only.
REQ-029 mem_rden SHALL be low outside READ; mem_rdaddress is don't-care when mem_rden low.

Reset
REQ-030 reset_n low SHALL immediately force IDLE; busy, done, mem_rden, out_valid = 0; mem_rdaddress, out_data = 0; FIFO empty.
REQ-031 Reset mid-burst SHALL discard the in-flight read; mem_q in the cycle after reset release SHALL NOT enter the FIFO.
REQ-032 First start SHALL be accepted on the first rising edge after reset_n deasserts.

Structure
REQ-033 Shared package mem_pkg SHALL hold the CLOG2 function and the FSM state enumeration.
REQ-034 One sub-module, mem_rd_fifo: 3-entry synchronous FIFO with push, pop, count, registered-free output of head entry.
REQ-035 Top level holds FSM, address counter (AW bits), issue counter (AW+1 bits), in-flight flag.

Verification (WIDTH=8, DEPTH=64, memory preloaded mem[i]=i)
REQ-036 start, base_addr=5, length=4, out_ready=1 -> out_data 5,6,7,8 on consecutive cycles, first out_valid 3 cycles after start sampled, done pulse after last word.
REQ-037 base_addr=62, length=4 -> out_data 62,63,0,1 (wrap).
REQ-038 length=0 -> no mem_rden, no out_valid, done pulse the cycle after start.
REQ-039 base_addr=0, length=10, out_ready toggled randomly and held low 5 cycles -> outputs 0..9 in order, out_data stable while stalled, never more than 3 reads outstanding+buffered.
REQ-040 reset_n low during burst at word 3 -> all outputs 0 immediately; after release, new burst base=20, length=2 -> 20,21 only.
REQ-041 start pulsed during busy with different base -> ignored, original burst completes unchanged.
